// File: rtl/uart_tx_fifo.sv
// UART transmitter with parametrised payload width, input FIFO, programmable prescaler, parity and 1/2 stop bits.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN (adds the send_break port).
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
`ifdef UART_TX_BREAK_EN
  input  logic                   send_break,
`endif
  output logic                   TX_OUT,
  output logic                   busy,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [AW:0]            count, count_nxt;
  logic [DATA_WIDTH-1:0]  head, data_r;
  logic [PRESC_WIDTH-1:0] presc_in_m1, presc_r, cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   par_r, par_en_r, stop2_r, stop_left;
  logic                   wr, pop, stop_end, brk;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  assign brk = 1'b0;
`endif

  assign head        = mem[rptr];
  assign presc_in_m1 = (PRESCALE == '0) ? '0 : PRESCALE - PRESC_WIDTH'(1);
  assign wr          = Data_Valid && !fifo_full;
  assign stop_end    = (state == STOP) && (cnt == '0) && !stop_left;
  // A pending break takes priority over starting the next queued word.
  assign pop         = !fifo_empty && !brk && ((state == IDLE) || stop_end);

  always_comb begin
    count_nxt = count;
    if (wr && !pop)      count_nxt = count + 1'b1;
    else if (!wr && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= P_DATA;
  end

  // Flags are registered from the next-state count so they line up with the pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count      <= count_nxt;
      fifo_full  <= (count_nxt == DEPTH_C);
      fifo_empty <= (count_nxt == '0);
      ovf        <= Data_Valid && fifo_full;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      presc_r   <= '0;
      bit_cnt   <= '0;
      data_r    <= '0;
      par_r     <= 1'b0;
      par_en_r  <= 1'b0;
      stop2_r   <= 1'b0;
      stop_left <= 1'b0;
    end else if (pop) begin
      state    <= START;
      TX_OUT   <= 1'b0;
      busy     <= 1'b1;
      data_r   <= head;
      par_r    <= ^head ^ PAR_TYP;
      par_en_r <= PAR_EN;
      stop2_r  <= STOP2;
      presc_r  <= presc_in_m1;
      cnt      <= presc_in_m1;
    end else begin
      if (state != IDLE && cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state  <= BREAK;
            TX_OUT <= 1'b0;
            busy   <= 1'b1;
          end
`endif
        end
        START: if (cnt == '0) begin
          state   <= DATA;
          TX_OUT  <= data_r[0];
          bit_cnt <= '0;
          cnt     <= presc_r;
        end
        DATA: if (cnt == '0) begin
          cnt <= presc_r;
          if (bit_cnt == LAST_BIT) begin
            if (par_en_r) begin
              state  <= PARITY;
              TX_OUT <= par_r;
            end else begin
              state     <= STOP;
              TX_OUT    <= 1'b1;
              stop_left <= stop2_r;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            data_r  <= data_r >> 1;
            TX_OUT  <= data_r[1];
          end
        end
        PARITY: if (cnt == '0) begin
          state     <= STOP;
          TX_OUT    <= 1'b1;
          stop_left <= stop2_r;
          cnt       <= presc_r;
        end
        STOP: if (cnt == '0) begin
          if (stop_left) begin
            stop_left <= 1'b0;
            cnt       <= presc_r;
`ifdef UART_TX_BREAK_EN
          end else if (brk) begin
            state  <= BREAK;
            TX_OUT <= 1'b0;
            busy   <= 1'b1;
`endif
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        end
`ifdef UART_TX_BREAK_EN
        // Release is followed by one stop-bit time at the current prescale.
        BREAK: if (!brk) begin
          state     <= STOP;
          TX_OUT    <= 1'b1;
          stop_left <= 1'b0;
          presc_r   <= presc_in_m1;
          cnt       <= presc_in_m1;
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised + directed bench for uart_tx_fifo; reference model expands each popped word into a per-cycle TX waveform.
module tb_uart_tx_fifo;
  localparam int DW = 8, DEPTH = 4, PW = 16;

  logic          CLK = 1'b0, RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [PW-1:0] PRESCALE = 16'd1;
  logic          TX_OUT, busy, fifo_full, fifo_empty, ovf;

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESC_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .TX_OUT(TX_OUT), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame as a queue of per-cycle line values.
  logic [DW-1:0] mq[$];
  logic          mw[$];
  logic          m_tx = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_empty = 1'b1, m_ovf = 1'b0;
  bit            full_pre;

  task automatic build_frame(input logic [DW-1:0] w);
    int   p;
    logic bits[$];
    p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (PAR_EN) bits.push_back((^w) ^ PAR_TYP);
    bits.push_back(1'b1);
    if (STOP2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < p; k++) mw.push_back(bits[i]);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete(); mw.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_full = 1'b0; m_empty = 1'b1; m_ovf = 1'b0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      if (mw.size() != 0) begin
        m_tx = mw.pop_front(); m_busy = 1'b1;
      end else if (mq.size() != 0) begin
        build_frame(mq.pop_front());
        m_tx = mw.pop_front(); m_busy = 1'b1;
      end else begin
        m_tx = 1'b1; m_busy = 1'b0;
      end
      m_ovf = Data_Valid && full_pre;
      if (Data_Valid && !full_pre) mq.push_back(P_DATA);
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
    end
  end

  always @(negedge CLK) begin
    chk("tx", TX_OUT, m_tx);
    chk("busy", busy, m_busy);
    chk("fifo_full", fifo_full, m_full);
    chk("fifo_empty", fifo_empty, m_empty);
    chk("ovf", ovf, m_ovf);
  end

  // Length of the most recent contiguous busy run, in cycles.
  int cur_run = 0, last_run = 0;
  always @(negedge CLK) begin
    if (busy) cur_run++;
    else if (cur_run != 0) begin last_run = cur_run; cur_run = 0; end
  end

  task automatic wr(input logic [DW-1:0] d);
    @(negedge CLK); Data_Valid = 1'b1; P_DATA = d;
  endtask

  task automatic drop_dv();
    @(negedge CLK); Data_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !fifo_empty) && n < 5000) begin @(negedge CLK); n++; end
    if (n >= 5000) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic cfg(input logic pe, input logic pt, input logic s2, input int p);
    @(negedge CLK); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = PW'(p);
  endtask

  int e2[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    @(negedge CLK);
    chk("rst_tx", TX_OUT, 1); chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1); chk("rst_full", fifo_full, 0); chk("rst_ovf", ovf, 0);
    @(negedge CLK); RST = 1'b0;

    // A5, even parity, one stop, 1 cycle per bit
    cfg(1, 0, 0, 1);
    wr(8'hA5); drop_dv();
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      chk("t2_tx", TX_OUT, e2[i]); chk("t2_busy", busy, 1);
    end
    @(negedge CLK); chk("t2_busy_end", busy, 0);
    wait_idle();

    // 01, odd parity, two stops, 16 cycles per bit
    cfg(1, 1, 1, 16);
    wr(8'h01); drop_dv();
    for (int c = 0; c < 192; c++) begin
      @(negedge CLK);
      if (c == 5)   chk("t3_start", TX_OUT, 0);
      if (c == 20)  chk("t3_bit0", TX_OUT, 1);
      if (c == 40)  chk("t3_bit1", TX_OUT, 0);
      if (c == 150) chk("t3_parity", TX_OUT, 0);
      if (c == 185) chk("t3_stop2", TX_OUT, 1);
    end
    wait_idle();
    chk("t3_len", last_run, 192);

    // back-to-back frames
    cfg(0, 0, 0, 1);
    wr(8'h00); wr(8'hFF); wr(8'h3C); drop_dv();
    wait_idle();
    chk("t4_len", last_run, 30);

    // overflow: sixth write dropped
    cfg(0, 0, 0, 8);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 5) chk("t5_full", fifo_full, 1);
      Data_Valid = 1'b1; P_DATA = DW'(8'h11 + i);
    end
    @(negedge CLK); Data_Valid = 1'b0;
    chk("t5_ovf", ovf, 1);
    wait_idle();
    chk("t5_len", last_run, 400);

    // config change mid-frame applies only to the next frame
    cfg(0, 0, 0, 4);
    wr(8'h96); drop_dv();
    repeat (9) @(negedge CLK);
    @(negedge CLK); PAR_EN = 1'b1; PRESCALE = 16'd2; Data_Valid = 1'b1; P_DATA = 8'h4B;
    drop_dv();
    wait_idle();
    chk("t6_len", last_run, 62);

    // reset mid-frame with a word queued
    cfg(0, 0, 0, 4);
    wr(8'h5A); drop_dv();
    repeat (8) @(negedge CLK);
    wr(8'h33); drop_dv();
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("t1_tx", TX_OUT, 1); chk("t1_busy", busy, 0);
    chk("t1_empty", fifo_empty, 1); chk("t1_full", fifo_full, 0);
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); chk("t1_quiet", TX_OUT, 1);
    end

    // randomised traffic, config churn and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = DW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
        PRESCALE = PW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
      end
    end
    @(negedge CLK); Data_Valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
